ps2_keycode_rx: RTL and testbench

- Keyboard front end that produces the 8-bit keycode consumed by the character/ball movement logic. That logic expects HID usages: 0x04 A, 0x07 D, 0x16 S, 0x1A W.
- Receives PS/2 scan-code set 2 frames from the keyboard, tracks make/break and extended prefixes, and maps each key to its HID usage.
- Holds the keycode while the key is down and drives 0x00 when no mapped key is held.
- Sits between the board PS/2 pins and the game logic, in the Clk domain.

---
 rtl/ps2_pkg.sv | 72 +++++++
 rtl/ps2_frame_rx.sv | 120 ++++++++++++
 rtl/ps2_keycode_rx.sv | 87 ++++++++
 tb/tb_ps2_keycode_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 set-2 scan codes, HID usages, frame states and the scan-to-HID lookup.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ps2_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_ESC   = 8'h29;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] usage;
    } map_t;

    function automatic map_t scan2hid(input logic ext, input logic [7:0] code);
        map_t m;
        m.hit   = 1'b1;
        m.usage = HID_NONE;
        if (!ext) begin
            case (code)
                SC_A:     m.usage = HID_A;
                SC_D:     m.usage = HID_D;
                SC_S:     m.usage = HID_S;
                SC_W:     m.usage = HID_W;
                SC_SPACE: m.usage = HID_SPACE;
                SC_ENTER: m.usage = HID_ENTER;
                SC_ESC:   m.usage = HID_ESC;
                default:  m.hit   = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    m.usage = HID_UP;
                SC_DOWN:  m.usage = HID_DOWN;
                SC_LEFT:  m.usage = HID_LEFT;
                SC_RIGHT: m.usage = HID_RIGHT;
                default:  m.hit   = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, 11-bit frame FSM, idle timeout.
// Latency: byte_valid / frame_err pulse 1 Clk after the cycle the stop-bit fall is detected.
// Backpressure: none; the keyboard cannot be stalled, every byte is presented once.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall;
    logic          bit_in;

    frame_state_t  state,      state_nxt;
    logic [7:0]    shift_q,    shift_nxt;
    logic [2:0]    bit_cnt,    bit_cnt_nxt;
    logic          par_q,      par_nxt;
    logic [TW-1:0] tmo_cnt,    tmo_nxt;
    logic          vld_nxt;
    logic          err_nxt;

    // Sync flops reset high so a reset never manufactures a falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            par_q      <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            par_q      <= par_nxt;
            tmo_cnt    <= tmo_nxt;
            byte_valid <= vld_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_q;
        tmo_nxt     = '0;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;

        if (state != IDLE && !fall) begin
            tmo_nxt = tmo_cnt + 1'b1;
        end

        if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {bit_in, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = bit_in;
                    state_nxt = STOP;
                end
                STOP: begin
                    // Odd parity over data+parity, and the stop bit must be high.
                    if (bit_in && (^{shift_q, par_q})) begin
                        vld_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            tmo_nxt   = '0;
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard front end: decodes E0/F0 prefixes and make/break into a held HID keycode.
// Latency: keycode/key_event update on the 2nd Clk edge after the stop-bit fall is detected.
// Backpressure: none; keycode is a level, key_event and frame_err are single-cycle pulses.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       ext,         ext_nxt;
    logic       brk,         brk_nxt;
    logic [7:0] keycode_nxt;
    logic       evt_nxt;
    map_t       map_res;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign map_res = scan2hid(ext, rx_byte);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keycode   <= HID_NONE;
            key_event <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            keycode   <= keycode_nxt;
            key_event <= evt_nxt;
            ext       <= ext_nxt;
            brk       <= brk_nxt;
        end
    end

    always_comb begin
        keycode_nxt = keycode;
        evt_nxt     = 1'b0;
        ext_nxt     = ext;
        brk_nxt     = brk;

        // A damaged frame may have been a prefix, so pending prefixes are dropped.
        if (frame_err) begin
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_E0) begin
                ext_nxt = 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk_nxt = 1'b1;
            end else begin
                ext_nxt = 1'b0;
                brk_nxt = 1'b0;
                if (map_res.hit) begin
                    if (brk) begin
                        if (map_res.usage == keycode) begin
                            keycode_nxt = HID_NONE;
                            evt_nxt     = 1'b1;
                        end
                    end else if (map_res.usage != keycode) begin
                        keycode_nxt = map_res.usage;
                        evt_nxt     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of key actions plus hand-written error, timeout and reset sequences.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    always #10 Clk = ~Clk;

    ps2_keycode_rx #(
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         err_seen = 0;
    int         last_evt_cyc = 0;
    int         stop_cyc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_kc;
        logic       exp_evt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every key_event pops one expected keycode.
    always @(negedge Clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (key_event === 1'b1) begin
            last_evt_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_key_event: keycode=0x%0h, no event expected", keycode);
            end else begin
                check("event_keycode", 32'(keycode), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge Clk);
        ps2_clk  = 1'b0;
        stop_cyc = cyc;
        repeat (HALF) @(negedge Clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_good ? ~^b : ^b);
        ps2_bit(stop_b);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge Clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] b, input logic [7:0] exp_kc, input logic exp_evt);
        if (exp_evt) exp_q.push_back(exp_kc);
        send_frame(b, 1'b1, 1'b1);
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        int waited;

        vecs.push_back('{2, 8'hF0, 8'h1D, 8'h00, 8'h00, 1'b1, "rel_W"});
        vecs.push_back('{1, 8'h1C, 8'h00, 8'h00, 8'h04, 1'b1, "mk_A"});
        vecs.push_back('{1, 8'h23, 8'h00, 8'h00, 8'h07, 1'b1, "mk_D"});
        vecs.push_back('{2, 8'hF0, 8'h1C, 8'h00, 8'h07, 1'b0, "brk_A_other"});
        vecs.push_back('{2, 8'hF0, 8'h23, 8'h00, 8'h00, 1'b1, "brk_D"});
        vecs.push_back('{2, 8'hE0, 8'h75, 8'h00, 8'h52, 1'b1, "mk_up"});
        vecs.push_back('{2, 8'hE0, 8'h75, 8'h00, 8'h52, 1'b0, "rep_up"});
        vecs.push_back('{1, 8'h75, 8'h00, 8'h00, 8'h52, 1'b0, "raw_75"});
        vecs.push_back('{3, 8'hE0, 8'hF0, 8'h75, 8'h00, 1'b1, "brk_up"});
        vecs.push_back('{1, 8'h29, 8'h00, 8'h00, 8'h2C, 1'b1, "mk_space"});
        vecs.push_back('{1, 8'h5A, 8'h00, 8'h00, 8'h28, 1'b1, "mk_enter"});
        vecs.push_back('{1, 8'h76, 8'h00, 8'h00, 8'h29, 1'b1, "mk_esc"});
        vecs.push_back('{2, 8'hE0, 8'h72, 8'h00, 8'h51, 1'b1, "mk_down"});
        vecs.push_back('{2, 8'hE0, 8'h6B, 8'h00, 8'h50, 1'b1, "mk_left"});
        vecs.push_back('{2, 8'hE0, 8'h74, 8'h00, 8'h4F, 1'b1, "mk_right"});
        vecs.push_back('{1, 8'h1B, 8'h00, 8'h00, 8'h16, 1'b1, "mk_S"});
        vecs.push_back('{1, 8'h1D, 8'h00, 8'h00, 8'h1A, 1'b1, "mk_W"});
        vecs.push_back('{2, 8'hF0, 8'h1B, 8'h00, 8'h1A, 1'b0, "brk_S_other"});
        vecs.push_back('{2, 8'hF0, 8'h1D, 8'h00, 8'h00, 1'b1, "brk_W"});
        vecs.push_back('{1, 8'h1C, 8'h00, 8'h00, 8'h04, 1'b1, "mk_A2"});
        vecs.push_back('{2, 8'hE0, 8'h1C, 8'h00, 8'h04, 1'b0, "ext_1C_unmapped"});
        vecs.push_back('{1, 8'h23, 8'h00, 8'h00, 8'h07, 1'b1, "mk_D_after_ext"});
        vecs.push_back('{2, 8'hF0, 8'h23, 8'h00, 8'h00, 1'b1, "brk_D2"});
        vecs.push_back('{1, 8'h1C, 8'h00, 8'h00, 8'h04, 1'b1, "mk_A3"});

        Reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_keycode",   32'(keycode),   32'h00);
        check("rst_key_event", 32'(key_event), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_state",     32'(u_dut.u_frame.state), 32'(IDLE));
        Reset = 1'b0;
        repeat (4) @(negedge Clk);

        // Make W with latency: 2 cycles of sync + 2 edges after fall detect.
        exp_q.push_back(8'h1A);
        send_frame(8'h1D, 1'b1, 1'b1);
        check("mkW_latency", 32'(last_evt_cyc - stop_cyc), 32'd4);
        check("mkW_keycode", 32'(keycode), 32'h1A);
        check("mkW_q_empty", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t       v;
            logic [7:0] bs [3];
            v = vecs[i];
            bs[0] = v.b0;
            bs[1] = v.b1;
            bs[2] = v.b2;
            for (int j = 0; j < v.n; j++) begin
                send_key(bs[j], v.exp_kc, (j == v.n - 1) && v.exp_evt);
            end
            check({"q_empty_", v.name}, 32'(exp_q.size()), 32'd0);
            check({"kc_", v.name}, 32'(keycode), 32'(v.exp_kc));
            exp_q.delete();
        end
        check("table_no_frame_err", 32'(err_seen), 32'd0);

        // Parity error after F0: error pulse, and the pending break is dropped.
        e0 = err_seen;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b0, 1'b1);
        check("parity_err", 32'(err_seen), 32'(e0 + 1));
        send_key(8'h1C, 8'h04, 1'b0);
        check("parity_err_kc", 32'(keycode), 32'h04);

        e0 = err_seen;
        send_frame(8'h1D, 1'b1, 1'b0);
        check("stop_err", 32'(err_seen), 32'(e0 + 1));
        check("stop_err_kc", 32'(keycode), 32'h04);

        // Timeout after F0 + partial frame; the following 1C must be a make.
        send_key(8'h23, 8'h07, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        e0 = err_seen;
        send_partial(8'h1D, 4);
        waited = 0;
        while (err_seen == e0 && waited < 3 * TMO) begin
            @(negedge Clk);
            waited++;
        end
        check("timeout_err", 32'(err_seen), 32'(e0 + 1));
        check("timeout_window", 32'(waited >= TMO - 2 * HALF && waited <= TMO + 2 * HALF), 32'd1);
        repeat (HALF) @(negedge Clk);
        send_key(8'h1C, 8'h04, 1'b1);
        check("after_timeout_kc", 32'(keycode), 32'h04);
        check("after_timeout_q", 32'(exp_q.size()), 32'd0);

        // Reset after 3 data bits while S is held.
        send_key(8'h1B, 8'h16, 1'b1);
        check("pre_reset_kc", 32'(keycode), 32'h16);
        send_partial(8'h1B, 3);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_keycode", 32'(keycode), 32'h00);
        check("midrst_key_event", 32'(key_event), 32'h0);
        check("midrst_state", 32'(u_dut.u_frame.state), 32'(IDLE));
        repeat (4 * HALF) @(negedge Clk);
        send_key(8'h1B, 8'h16, 1'b1);
        check("post_reset_kc", 32'(keycode), 32'h16);
        check("post_reset_q", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
